// File: rtl/wb_xbar_pkg.sv
// Shared types and the default rv32i SoC address map for the Wishbone 1-to-N router.
package wb_xbar_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESP   = 2'd2
    } xbar_state_e;

    localparam logic [31:0] IMEM_BASE = 32'h0000_0000;
    localparam logic [31:0] IMEM_MASK = 32'hFFFF_F000;
    localparam logic [31:0] DMEM_BASE = 32'h8000_0000;
    localparam logic [31:0] DMEM_MASK = 32'hFFFF_F000;
    localparam logic [31:0] UART_BASE = 32'h2000_0000;
    localparam logic [31:0] UART_MASK = 32'hFFFF_FF00;
    localparam logic [31:0] GPIO_BASE = 32'h2000_0100;
    localparam logic [31:0] GPIO_MASK = 32'hFFFF_FF00;
    localparam logic [31:0] SPI_BASE  = 32'h2000_0200;
    localparam logic [31:0] SPI_MASK  = 32'hFFFF_FF00;

    // Slave index width; a single-slave build still gets a 1-bit index.
    function automatic int clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wb_addr_decoder.sv
// Combinational mask/base address match with lowest-index-wins priority.
module wb_addr_decoder
    import wb_xbar_pkg::*;
#(
    parameter int NUM_SLAVES = 5,
    parameter int ADDR_W     = 32,
    parameter int IDX_W      = clog2(NUM_SLAVES),
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = '0
) (
    input  logic [ADDR_W-1:0] i_adr,
    output logic              o_hit,
    output logic [IDX_W-1:0]  o_idx
);

    logic [NUM_SLAVES-1:0] w_match;

    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_match
        assign w_match[g] = ((i_adr & SLAVE_MASK[g*ADDR_W +: ADDR_W])
                             == SLAVE_BASE[g*ADDR_W +: ADDR_W]);
    end

    // Scan from the top down so the lowest matching index is the last one written.
    always_comb begin
        o_hit = |w_match;
        o_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            o_idx = w_match[i] ? IDX_W'(i) : o_idx;
        end
    end

endmodule

// File: rtl/wb_xbar_n.sv
// Wishbone classic 1-master-to-N-slave router with registered request/response,
// decode-error termination, a per-transfer watchdog and master-abort handling.
module wb_xbar_n
    import wb_xbar_pkg::*;
#(
    parameter int NUM_SLAVES     = 5,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE =
        {SPI_BASE, GPIO_BASE, UART_BASE, DMEM_BASE, IMEM_BASE},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK =
        {SPI_MASK, GPIO_MASK, UART_MASK, DMEM_MASK, IMEM_MASK}
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [ADDR_W-1:0]            wbm_adr_i,
    input  logic [DATA_W-1:0]            wbm_dat_i,
    input  logic [DATA_W/8-1:0]          wbm_sel_i,
    input  logic                         wbm_we_i,
    input  logic                         wbm_cyc_i,
    input  logic                         wbm_stb_i,
    output logic [DATA_W-1:0]            wbm_dat_o,
    output logic                         wbm_ack_o,
    output logic                         wbm_err_o,
    output logic [ADDR_W-1:0]            wbs_adr_o,
    output logic [DATA_W-1:0]            wbs_dat_o,
    output logic [DATA_W/8-1:0]          wbs_sel_o,
    output logic                         wbs_we_o,
    output logic [NUM_SLAVES-1:0]        wbs_cyc_o,
    output logic [NUM_SLAVES-1:0]        wbs_stb_o,
    input  logic [NUM_SLAVES*DATA_W-1:0] wbs_dat_i,
    input  logic [NUM_SLAVES-1:0]        wbs_ack_i,
    input  logic [NUM_SLAVES-1:0]        wbs_err_i,
    output logic                         busy_o,
    output logic                         timeout_o
);

    localparam int IDX_W = clog2(NUM_SLAVES);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    xbar_state_e              r_state, w_state_nxt;
    logic [CNT_W-1:0]         r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]         r_idx, w_idx_nxt;
    logic [ADDR_W-1:0]        r_adr, w_adr_nxt;
    logic [DATA_W-1:0]        r_wdat, w_wdat_nxt;
    logic [DATA_W/8-1:0]      r_sel, w_sel_nxt;
    logic                     r_we, w_we_nxt;
    logic [NUM_SLAVES-1:0]    r_cs, w_cs_nxt;
    logic [DATA_W-1:0]        r_rdat, w_rdat_nxt;
    logic                     r_ack, w_ack_nxt;
    logic                     r_err, w_err_nxt;
    logic                     r_tmo, w_tmo_nxt;
    logic                     r_busy;
    logic                     w_hit, w_req, w_s_ack, w_s_err, w_expired;
    logic [IDX_W-1:0]         w_dec_idx;

    wb_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W),
        .IDX_W      (IDX_W),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_dec (
        .i_adr (wbm_adr_i),
        .o_hit (w_hit),
        .o_idx (w_dec_idx)
    );

    assign w_req     = wbm_cyc_i & wbm_stb_i;
    assign w_s_ack   = wbs_ack_i[r_idx];
    assign w_s_err   = wbs_err_i[r_idx];
    assign w_expired = (r_cnt == CNT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort outranks err, err outranks ack, ack outranks timeout.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_state_nxt = w_hit ? ACTIVE : RESP;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ACTIVE: begin
                if (!wbm_cyc_i) begin
                    w_state_nxt = IDLE;
                end else if (w_s_err || w_s_ack || w_expired) begin
                    w_state_nxt = RESP;
                end else begin
                    w_state_nxt = ACTIVE;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and latched request.
    always_comb begin
        w_cnt_nxt  = '0;
        w_idx_nxt  = r_idx;
        w_adr_nxt  = r_adr;
        w_wdat_nxt = r_wdat;
        w_sel_nxt  = r_sel;
        w_we_nxt   = r_we;
        w_cs_nxt   = '0;
        w_rdat_nxt = r_rdat;
        w_ack_nxt  = 1'b0;
        w_err_nxt  = 1'b0;
        w_tmo_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req && w_hit) begin
                    w_idx_nxt  = w_dec_idx;
                    w_adr_nxt  = wbm_adr_i;
                    w_wdat_nxt = wbm_dat_i;
                    w_sel_nxt  = wbm_sel_i;
                    w_we_nxt   = wbm_we_i;
                    w_cs_nxt   = NUM_SLAVES'(1'b1) << w_dec_idx;
                end else if (w_req) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_cs_nxt = '0;
                end
            end
            ACTIVE: begin
                if (!wbm_cyc_i) begin
                    w_cs_nxt = '0;
                end else if (w_s_err) begin
                    w_err_nxt = 1'b1;
                end else if (w_s_ack) begin
                    w_ack_nxt  = 1'b1;
                    w_rdat_nxt = r_we ? r_rdat : wbs_dat_i[r_idx*DATA_W +: DATA_W];
                end else if (w_expired) begin
                    w_err_nxt = 1'b1;
                    w_tmo_nxt = 1'b1;
                end else begin
                    w_cs_nxt  = r_cs;
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            RESP:    w_cs_nxt = '0;
            default: w_cs_nxt = '0;
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_idx  <= '0;
            r_adr  <= '0;
            r_wdat <= '0;
            r_sel  <= '0;
            r_we   <= 1'b0;
            r_cs   <= '0;
            r_rdat <= '0;
            r_ack  <= 1'b0;
            r_err  <= 1'b0;
            r_tmo  <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_idx  <= w_idx_nxt;
            r_adr  <= w_adr_nxt;
            r_wdat <= w_wdat_nxt;
            r_sel  <= w_sel_nxt;
            r_we   <= w_we_nxt;
            r_cs   <= w_cs_nxt;
            r_rdat <= w_rdat_nxt;
            r_ack  <= w_ack_nxt;
            r_err  <= w_err_nxt;
            r_tmo  <= w_tmo_nxt;
            r_busy <= (w_state_nxt != IDLE);
        end
    end

    assign wbm_dat_o = r_rdat;
    assign wbm_ack_o = r_ack;
    assign wbm_err_o = r_err;
    assign wbs_adr_o = r_adr;
    assign wbs_dat_o = r_wdat;
    assign wbs_sel_o = r_sel;
    assign wbs_we_o  = r_we;
    assign wbs_cyc_o = r_cs;
    assign wbs_stb_o = r_cs;
    assign busy_o    = r_busy;
    assign timeout_o = r_tmo;

endmodule

// File: tb/tb_wb_xbar_n.sv
// Directed self-checking bench for wb_xbar_n with an 8-cycle watchdog.
module tb_wb_xbar_n;

    localparam int NS = 5;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [AW-1:0]     wbm_adr_i;
    logic [DW-1:0]     wbm_dat_i;
    logic [DW/8-1:0]   wbm_sel_i;
    logic              wbm_we_i, wbm_cyc_i, wbm_stb_i;
    logic [DW-1:0]     wbm_dat_o;
    logic              wbm_ack_o, wbm_err_o;
    logic [AW-1:0]     wbs_adr_o;
    logic [DW-1:0]     wbs_dat_o;
    logic [DW/8-1:0]   wbs_sel_o;
    logic              wbs_we_o;
    logic [NS-1:0]     wbs_cyc_o, wbs_stb_o;
    logic [NS*DW-1:0]  wbs_dat_i;
    logic [NS-1:0]     wbs_ack_i, wbs_err_i;
    logic              busy_o, timeout_o;

    int passed = 0;
    int total  = 0;

    wb_xbar_n #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
        .wbm_we_i(wbm_we_i), .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
        .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
        .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
        .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
        .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
        .busy_o(busy_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic master_req(input logic [31:0] adr, input logic [31:0] dat,
                              input logic [3:0] sel, input logic we);
        @(negedge clk);
        wbm_adr_i = adr; wbm_dat_i = dat; wbm_sel_i = sel; wbm_we_i = we;
        wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
    endtask

    task automatic master_drop();
        wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
        wbs_ack_i = '0; wbs_err_i = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '0; wbm_we_i = 1'b0;
        wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
        wbs_dat_i = '0; wbs_ack_i = '0; wbs_err_i = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({wbm_ack_o, wbm_err_o, busy_o, timeout_o, wbs_we_o} !== 5'b00000)
            $display("FAIL reset_flags: got %b want 00000",
                     {wbm_ack_o, wbm_err_o, busy_o, timeout_o, wbs_we_o});
        else passed++;
        total++;
        if ({wbs_cyc_o, wbs_stb_o, wbm_dat_o, wbs_adr_o} !== '0)
            $display("FAIL reset_bus: cyc=%b stb=%b mdat=%h adr=%h want 0",
                     wbs_cyc_o, wbs_stb_o, wbm_dat_o, wbs_adr_o);
        else passed++;
        reset_n = 1'b1;
    endtask

    task automatic test_read_dmem();
        master_req(32'h8000_0010, 32'h0, 4'hF, 1'b0);
        @(negedge clk);
        total++;
        if (wbs_stb_o !== 5'b00010 || wbs_cyc_o !== 5'b00010 || wbm_ack_o !== 1'b0)
            $display("FAIL read_strobe: stb=%b cyc=%b ack=%b want 00010 00010 0",
                     wbs_stb_o, wbs_cyc_o, wbm_ack_o);
        else passed++;
        total++;
        if (wbs_adr_o !== 32'h8000_0010 || busy_o !== 1'b1)
            $display("FAIL read_adr: adr=%h busy=%b want 80000010 1", wbs_adr_o, busy_o);
        else passed++;
        wbs_dat_i[1*DW +: DW] = 32'hDEAD_BEEF;
        wbs_ack_i = 5'b00010;
        @(negedge clk);
        total++;
        if (wbm_ack_o !== 1'b1 || wbm_err_o !== 1'b0 || wbm_dat_o !== 32'hDEAD_BEEF)
            $display("FAIL read_ack: ack=%b err=%b dat=%h want 1 0 deadbeef",
                     wbm_ack_o, wbm_err_o, wbm_dat_o);
        else passed++;
        total++;
        if (wbs_cyc_o !== 5'b00000)
            $display("FAIL read_cyc_drop: got %b want 00000", wbs_cyc_o);
        else passed++;
        master_drop();
        @(negedge clk);
        total++;
        if (wbm_ack_o !== 1'b0 || busy_o !== 1'b0)
            $display("FAIL read_idle: ack=%b busy=%b want 0 0", wbm_ack_o, busy_o);
        else passed++;
    endtask

    task automatic test_write_gpio();
        master_req(32'h2000_0104, 32'h0000_00FF, 4'b0001, 1'b1);
        wbs_dat_i[3*DW +: DW] = 32'h5555_AAAA;
        @(negedge clk);
        total++;
        if (wbs_stb_o !== 5'b01000 || wbs_we_o !== 1'b1 || wbs_sel_o !== 4'b0001
            || wbs_dat_o !== 32'h0000_00FF)
            $display("FAIL write_setup: stb=%b we=%b sel=%b dat=%h want 01000 1 0001 000000ff",
                     wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_dat_o);
        else passed++;
        wbs_ack_i = 5'b00010;
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            total++;
            if (wbm_ack_o !== 1'b0 || wbs_stb_o !== 5'b01000)
                $display("FAIL write_wait%0d: ack=%b stb=%b want 0 01000", c, wbm_ack_o, wbs_stb_o);
            else passed++;
            wbs_ack_i = (c == 4) ? 5'b01000 : 5'b00000;
        end
        @(negedge clk);
        total++;
        if (wbm_ack_o !== 1'b1 || wbm_dat_o !== 32'hDEAD_BEEF)
            $display("FAIL write_ack: ack=%b dat=%h want 1 deadbeef", wbm_ack_o, wbm_dat_o);
        else passed++;
        master_drop();
        @(negedge clk);
    endtask

    task automatic test_decode_miss();
        master_req(32'h4000_0000, 32'h0, 4'hF, 1'b0);
        @(negedge clk);
        total++;
        if (wbm_err_o !== 1'b1 || wbm_ack_o !== 1'b0 || wbs_cyc_o !== 5'b00000)
            $display("FAIL miss_err: err=%b ack=%b cyc=%b want 1 0 00000",
                     wbm_err_o, wbm_ack_o, wbs_cyc_o);
        else passed++;
        total++;
        if (wbs_adr_o !== 32'h2000_0104)
            $display("FAIL miss_hold_adr: got %h want 20000104", wbs_adr_o);
        else passed++;
        master_drop();
        @(negedge clk);
        total++;
        if (wbm_err_o !== 1'b0 || wbs_cyc_o !== 5'b00000)
            $display("FAIL miss_after: err=%b cyc=%b want 0 00000", wbm_err_o, wbs_cyc_o);
        else passed++;
    endtask

    task automatic test_timeout();
        int strobes = 0;
        master_req(32'h2000_0000, 32'h0, 4'hF, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (wbs_stb_o === 5'b00100 && wbm_err_o === 1'b0 && timeout_o === 1'b0)
                strobes++;
        end
        total++;
        if (strobes !== 8)
            $display("FAIL tmo_strobes: got %0d want 8", strobes);
        else passed++;
        @(negedge clk);
        total++;
        if (timeout_o !== 1'b1 || wbm_err_o !== 1'b1 || wbm_ack_o !== 1'b0
            || wbs_cyc_o !== 5'b00000)
            $display("FAIL tmo_fire: tmo=%b err=%b ack=%b cyc=%b want 1 1 0 00000",
                     timeout_o, wbm_err_o, wbm_ack_o, wbs_cyc_o);
        else passed++;
        master_drop();
        @(negedge clk);
        total++;
        if (timeout_o !== 1'b0 || wbm_err_o !== 1'b0)
            $display("FAIL tmo_pulse: tmo=%b err=%b want 0 0", timeout_o, wbm_err_o);
        else passed++;
    endtask

    task automatic test_ack_err_same();
        master_req(32'h8000_0020, 32'h0, 4'hF, 1'b0);
        @(negedge clk);
        wbs_dat_i[1*DW +: DW] = 32'h0BAD_0BAD;
        wbs_ack_i = 5'b00010;
        wbs_err_i = 5'b00010;
        @(negedge clk);
        total++;
        if (wbm_err_o !== 1'b1 || wbm_ack_o !== 1'b0 || wbm_dat_o !== 32'hDEAD_BEEF)
            $display("FAIL ack_err: err=%b ack=%b dat=%h want 1 0 deadbeef",
                     wbm_err_o, wbm_ack_o, wbm_dat_o);
        else passed++;
        master_drop();
        @(negedge clk);
    endtask

    task automatic test_ack_on_expiry();
        master_req(32'h2000_0004, 32'h0, 4'hF, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 8) begin
                wbs_dat_i[2*DW +: DW] = 32'h1234_5678;
                wbs_ack_i = 5'b00100;
            end
        end
        @(negedge clk);
        total++;
        if (wbm_ack_o !== 1'b1 || wbm_err_o !== 1'b0 || timeout_o !== 1'b0
            || wbm_dat_o !== 32'h1234_5678)
            $display("FAIL ack_expiry: ack=%b err=%b tmo=%b dat=%h want 1 0 0 12345678",
                     wbm_ack_o, wbm_err_o, timeout_o, wbm_dat_o);
        else passed++;
        master_drop();
        @(negedge clk);
    endtask

    task automatic test_abort();
        int resp = 0;
        master_req(32'h2000_0108, 32'h0, 4'hF, 1'b0);
        @(negedge clk);
        total++;
        if (wbs_cyc_o !== 5'b01000)
            $display("FAIL abort_start: cyc=%b want 01000", wbs_cyc_o);
        else passed++;
        master_drop();
        wbs_ack_i = 5'b01000;
        @(negedge clk);
        total++;
        if (wbs_cyc_o !== 5'b00000 || busy_o !== 1'b0)
            $display("FAIL abort_drop: cyc=%b busy=%b want 00000 0", wbs_cyc_o, busy_o);
        else passed++;
        for (int c = 0; c < 3; c++) begin
            if (wbm_ack_o !== 1'b0 || wbm_err_o !== 1'b0) resp++;
            @(negedge clk);
        end
        wbs_ack_i = '0;
        total++;
        if (resp !== 0)
            $display("FAIL abort_noresp: got %0d responses want 0", resp);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int resp = 0;
        master_req(32'h2000_0200, 32'hCAFE_F00D, 4'b1111, 1'b1);
        @(negedge clk);
        total++;
        if (wbs_stb_o !== 5'b10000)
            $display("FAIL rst_mid_start: stb=%b want 10000", wbs_stb_o);
        else passed++;
        reset_n = 1'b0;
        wbs_ack_i = 5'b10000;
        @(negedge clk);
        total++;
        if ({wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbm_err_o, busy_o, timeout_o, wbs_we_o} !== '0
            || wbs_adr_o !== '0 || wbs_dat_o !== '0 || wbm_dat_o !== '0)
            $display("FAIL rst_mid_clear: cyc=%b ack=%b err=%b busy=%b adr=%h mdat=%h want all 0",
                     wbs_cyc_o, wbm_ack_o, wbm_err_o, busy_o, wbs_adr_o, wbm_dat_o);
        else passed++;
        master_drop();
        wbs_ack_i = 5'b10000;
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (wbm_ack_o !== 1'b0 || wbm_err_o !== 1'b0 || wbs_cyc_o !== 5'b00000) resp++;
        end
        wbs_ack_i = '0;
        total++;
        if (resp !== 0)
            $display("FAIL rst_mid_noresp: got %0d responses want 0", resp);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_read_dmem();
        test_write_gpio();
        test_decode_miss();
        test_timeout();
        test_ack_err_same();
        test_ack_on_expiry();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/wb_xbar_n.md
Name: wb_xbar_n

Overview:
- Parametrised 1-master-to-N-slave Wishbone classic decoder/router for the rv32i SoC.
- Sits between `wishbone_controller` and the peripherals (imem, dmem, uart, gpio, spi flash).
- Replaces the fixed-slave interconnect with mask/base address decoding and registered request/response.
- Adds decode-error termination, a bus timeout watchdog, and master-abort handling.

Parameters:
- NUM_SLAVES, 5: number of slave ports, 1..16.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; must be a multiple of 8.
- TIMEOUT_CYCLES, 255: maximum slave cycles before forced error; must be ≥1.
- SLAVE_BASE, {0x2000_0200, 0x2000_0100, 0x2000_0000, 0x8000_0000, 0x0000_0000}: flat NUM_SLAVES*ADDR_W base vector; index 0 is the LSB.
- SLAVE_MASK, {0xFFFF_FF00, 0xFFFF_FF00, 0xFFFF_FF00, 0xFFFF_F000, 0xFFFF_F000}: flat NUM_SLAVES*ADDR_W mask vector.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- wbm_adr_i  in  ADDR_W  master address.
- wbm_dat_i  in  DATA_W  master write data.
- wbm_sel_i  in  DATA_W/8  byte selects.
- wbm_we_i  in  1  write enable.
- wbm_cyc_i  in  1  master cycle.
- wbm_stb_i  in  1  master strobe.
- wbm_dat_o  out  DATA_W  read data to master.
- wbm_ack_o  out  1  normal termination.
- wbm_err_o  out  1  error termination (decode miss, slave err, timeout).
- wbs_adr_o  out  ADDR_W  registered address, shared by all slaves.
- wbs_dat_o  out  DATA_W  registered write data, shared.
- wbs_sel_o  out  DATA_W/8  registered byte selects, shared.
- wbs_we_o  out  1  registered write enable, shared.
- wbs_cyc_o  out  NUM_SLAVES  per-slave cycle, one-hot or zero.
- wbs_stb_o  out  NUM_SLAVES  per-slave strobe, one-hot or zero.
- wbs_dat_i  in  NUM_SLAVES*DATA_W  flat slave read data.
- wbs_ack_i  in  NUM_SLAVES  slave acks.
- wbs_err_i  in  NUM_SLAVES  slave errors.
- busy_o  out  1  high whenever the FSM is not IDLE.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset: all outputs are 0, state is IDLE, timeout counter is 0; takes effect at the first rising edge with reset_n low.
- Reset mid-transaction: the transfer is abandoned; no ack or err is ever issued for it.
- Decode: slave i matches when (wbm_adr_i & MASK[i]) == BASE[i].
  - The lowest matching index wins.
  - No match is a decode miss.
- IDLE:
  - wbm_cyc_i & wbm_stb_i with a match → latch adr/dat/sel/we and slave index; next state ACTIVE.
  - Same condition with a decode miss → next state RESP with err pending; no slave is touched.
- ACTIVE:
  - wbs_cyc_o[idx] and wbs_stb_o[idx] are high; all other bits are 0.
  - The counter increments each ACTIVE cycle.
- ACTIVE exits, evaluated each cycle in this priority order:
  1. wbm_cyc_i low (master abort) → deassert slave cyc/stb at the next edge, go IDLE, no response.
  2. wbs_err_i[idx] → RESP with err; err wins over a simultaneous ack.
  3. wbs_ack_i[idx] → capture wbs_dat_i slice idx into wbm_dat_o, go RESP with ack; ack wins over a same-cycle timeout.
  4. Counter == TIMEOUT_CYCLES-1 → drop slave cyc/stb, pulse timeout_o, go RESP with err.
- RESP:
  - Exactly one of wbm_ack_o / wbm_err_o is high for exactly one cycle.
  - Next state is always IDLE; the counter clears.
  - A new request is sampled in IDLE no earlier than the cycle after RESP, so the held stb is never double-accepted.
- wbm_dat_o:
  - Updated only on a read ack; holds its value otherwise.
  - Left unchanged on write acks and on errors.
- Latency: request sampled in cycle 0 → slave strobe in cycle 1 → slave ack in cycle 1 → master ack in cycle 2. Minimum is 2 cycles plus slave wait states.
- Decode-miss latency: err in cycle 1.
- Shared wbs_* outputs hold their last latched values while IDLE.
- Per-slave cyc/stb are never asserted outside ACTIVE.
- Acks/errs from non-selected slaves are ignored.

Decomposition:
- Package wb_xbar_pkg holds:
  - the state enum (IDLE, ACTIVE, RESP);
  - the default SoC address map constants (imem, dmem, uart, gpio, spi base/mask);
  - the index width function clog2(NUM_SLAVES).
- Sub-module wb_addr_decoder: combinational mask/base match and priority encode; outputs hit and idx.

Test Plan:
- Read from dmem: adr 0x8000_0010; slave 1 acks in its first strobe cycle with 0xDEAD_BEEF → wbs_stb_o=5'b00010 in cycle 1; wbm_ack_o in cycle 2; wbm_dat_o=0xDEAD_BEEF.
- Write to gpio: adr 0x2000_0104, dat 0x0000_00FF, sel 4'b0001; slave 3 acks after 3 wait states → wbs_we_o=1, wbs_sel_o=0001, wbm_ack_o 5 cycles after request; wbm_dat_o unchanged.
- Decode miss: adr 0x4000_0000 → wbm_err_o in cycle 1; wbs_cyc_o stays 0.
- Timeout with TIMEOUT_CYCLES=8: uart (0x2000_0000) never acks → slave strobe for 8 cycles; timeout_o and wbm_err_o pulse together; wbs_cyc_o drops.
- Simultaneous events:
  - wbs_ack_i and wbs_err_i both high → err only.
  - Ack on the timeout-expiry cycle → ack only, no timeout_o.
- Abort/reset:
  - Master drops cyc while in ACTIVE → slave cyc drops next edge, no ack.
  - reset_n low mid-ACTIVE → all outputs 0 next edge, no response afterwards.
